// File: rtl/td4x_pkg.sv
// Shared encodings for the td4x core: opcodes, ALU source select and run state.
package td4x_pkg;

  localparam logic [3:0] OP_ADDA  = 4'b0000;
  localparam logic [3:0] OP_MOVAB = 4'b0001;
  localparam logic [3:0] OP_INA   = 4'b0010;
  localparam logic [3:0] OP_MOVA  = 4'b0011;
  localparam logic [3:0] OP_MOVBA = 4'b0100;
  localparam logic [3:0] OP_ADDB  = 4'b0101;
  localparam logic [3:0] OP_INB   = 4'b0110;
  localparam logic [3:0] OP_MOVB  = 4'b0111;
  localparam logic [3:0] OP_SUBA  = 4'b1000;
  localparam logic [3:0] OP_OUTB  = 4'b1001;
  localparam logic [3:0] OP_HALT  = 4'b1010;
  localparam logic [3:0] OP_OUTI  = 4'b1011;
  localparam logic [3:0] OP_JZ    = 4'b1100;
  localparam logic [3:0] OP_JC    = 4'b1101;
  localparam logic [3:0] OP_JNC   = 4'b1110;
  localparam logic [3:0] OP_JMP   = 4'b1111;

  typedef enum logic [1:0] {SRC_A, SRC_B, SRC_IN, SRC_ZERO} src_sel_t;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

endpackage

// File: rtl/td4x_decoder.sv
// Combinational instruction decoder: picks the ALU source, the register to load
// and whether a jump is taken using the flags from before this instruction.
module td4x_decoder
  import td4x_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       cf,
  input  logic       zf,
  output src_sel_t   src_sel,
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_out,
  output logic       ld_pc,
  output logic       is_sub,
  output logic       is_halt
);

  always_comb begin
    src_sel = SRC_ZERO;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    ld_out  = 1'b0;
    ld_pc   = 1'b0;
    is_sub  = 1'b0;
    is_halt = 1'b0;
    case (opcode)
      OP_ADDA:  begin src_sel = SRC_A;  ld_a = 1'b1; end
      OP_MOVAB: begin src_sel = SRC_B;  ld_a = 1'b1; end
      OP_INA:   begin src_sel = SRC_IN; ld_a = 1'b1; end
      OP_MOVA:  ld_a = 1'b1;
      OP_MOVBA: begin src_sel = SRC_A;  ld_b = 1'b1; end
      OP_ADDB:  begin src_sel = SRC_B;  ld_b = 1'b1; end
      OP_INB:   begin src_sel = SRC_IN; ld_b = 1'b1; end
      OP_MOVB:  ld_b = 1'b1;
      OP_SUBA:  begin src_sel = SRC_A;  ld_a = 1'b1; is_sub = 1'b1; end
      OP_OUTB:  ld_out = 1'b1;
      OP_OUTI:  ld_out = 1'b1;
      OP_HALT:  is_halt = 1'b1;
      OP_JZ:    ld_pc = zf;
      OP_JC:    ld_pc = cf;
      OP_JNC:   ld_pc = ~cf;
      OP_JMP:   ld_pc = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/td4x_cpu_core.sv
// Parametrised TD4-style accumulator core with fetch stall, HALT/resume and
// an output strobe. Holds the register file, ALU, PC and run/halt FSM.
module td4x_cpu_core
  import td4x_pkg::*;
#(
  parameter  int DW  = 4,
  parameter  int AW  = 4,
  localparam int IMW = (DW > AW) ? DW : AW,
  localparam int IW  = 4 + IMW
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] address,
  input  logic [IW-1:0] data,
  input  logic          data_valid,
  input  logic [DW-1:0] port_i,
  output logic [DW-1:0] port_o,
  output logic          out_strobe,
  output logic          cf,
  output logic          zf,
  output logic          halted,
  input  logic          resume
);

  logic [3:0]    opcode;
  logic [IMW-1:0] imm;
  logic [DW-1:0] imm_dw;
  logic [DW-1:0] reg_a;
  logic [DW-1:0] reg_b;
  logic [DW-1:0] src;
  logic [DW:0]   alu_res;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_d;
  state_t        state;
  state_t        state_d;
  src_sel_t      src_sel;
  logic          ld_a, ld_b, ld_out, ld_pc, is_sub, is_halt;
  logic          exec;

  assign opcode  = data[IW-1:IMW];
  assign imm     = data[IMW-1:0];
  assign imm_dw  = imm[DW-1:0];
  assign exec    = (state == ST_RUN) && data_valid;
  assign address = pc;
  assign halted  = (state == ST_HALT);

  td4x_decoder u_decoder (
    .opcode (opcode),
    .cf     (cf),
    .zf     (zf),
    .src_sel(src_sel),
    .ld_a   (ld_a),
    .ld_b   (ld_b),
    .ld_out (ld_out),
    .ld_pc  (ld_pc),
    .is_sub (is_sub),
    .is_halt(is_halt)
  );

  always_comb begin
    src = '0;
    case (src_sel)
      SRC_A:   src = reg_a;
      SRC_B:   src = reg_b;
      SRC_IN:  src = port_i;
      default: src = '0;
    endcase
  end

  // Subtraction is two's-complement add, so carry-out doubles as "no borrow".
  always_comb begin
    if (is_sub)
      alu_res = {1'b0, reg_a} + {1'b0, ~imm_dw} + (DW+1)'(1);
    else
      alu_res = {1'b0, src} + {1'b0, imm_dw};
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_RUN:  if (exec && is_halt) state_d = ST_HALT;
      ST_HALT: if (resume) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // HALT parks the PC on its own address; resume then steps past it.
  always_comb begin
    pc_d = pc;
    if (state == ST_HALT) begin
      if (resume) pc_d = pc + AW'(1);
    end else if (data_valid) begin
      if (ld_pc)
        pc_d = imm[AW-1:0];
      else if (!is_halt)
        pc_d = pc + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_RUN;
      pc         <= '0;
      reg_a      <= '0;
      reg_b      <= '0;
      port_o     <= '0;
      out_strobe <= 1'b0;
      cf         <= 1'b0;
      zf         <= 1'b0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      out_strobe <= 1'b0;
      if (exec) begin
        cf <= alu_res[DW];
        zf <= (alu_res[DW-1:0] == '0);
        if (ld_a) reg_a <= alu_res[DW-1:0];
        if (ld_b) reg_b <= alu_res[DW-1:0];
        if (ld_out) begin
          port_o     <= (opcode == OP_OUTI) ? imm_dw : reg_b;
          out_strobe <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_td4x_cpu_core.sv
// Self-checking bench: a 4/4 core and an 8/6 core share the same instruction
// stream and are checked every cycle against an integer reference model.
module tb_td4x_cpu_core;
  import td4x_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_valid;
  logic        resume;
  logic [7:0]  data4;
  logic [3:0]  port_i4, port_o4, address4;
  logic        out_strobe4, cf4, zf4, halted4;
  logic [11:0] data8;
  logic [7:0]  port_i8, port_o8;
  logic [5:0]  address8;
  logic        out_strobe8, cf8, zf8, halted8;

  always #5 clk = ~clk;

  td4x_cpu_core #(.DW(4), .AW(4)) u_dut4 (
    .clk(clk), .rst(rst), .address(address4), .data(data4), .data_valid(data_valid),
    .port_i(port_i4), .port_o(port_o4), .out_strobe(out_strobe4), .cf(cf4), .zf(zf4),
    .halted(halted4), .resume(resume)
  );

  td4x_cpu_core #(.DW(8), .AW(6)) u_dut8 (
    .clk(clk), .rst(rst), .address(address8), .data(data8), .data_valid(data_valid),
    .port_i(port_i8), .port_o(port_o8), .out_strobe(out_strobe8), .cf(cf8), .zf(zf8),
    .halted(halted8), .resume(resume)
  );

  typedef struct {
    int a, b, out_val, pc, cf, zf, halted, strobe;
  } model_t;

  typedef struct {
    int op, imm, pin, pc, cf, zf, out_val, strobe;
  } vec_t;

  model_t m4, m8;
  vec_t   vecs[18];
  int     checks = 0;
  int     passes = 0;
  int     cycle  = 0;

  // Architectural behaviour of one clock edge, in plain integer arithmetic.
  function automatic model_t step(model_t s, int dw, int aw, int op, int imm, int pin,
                                  bit dv, bit rs, bit rstn);
    model_t n;
    int dmask = (1 << dw) - 1;
    int amask = (1 << aw) - 1;
    int iv    = imm & dmask;
    int src, res;
    n = s;
    n.strobe = 0;
    if (!rstn) return '{default: 0};
    if (s.halted != 0) begin
      if (rs) begin
        n.pc = (s.pc + 1) & amask;
        n.halted = 0;
      end
      return n;
    end
    if (!dv) return n;
    case (op)
      OP_ADDA, OP_SUBA, OP_MOVBA: src = s.a;
      OP_ADDB, OP_MOVAB:          src = s.b;
      OP_INA, OP_INB:             src = pin & dmask;
      default:                    src = 0;
    endcase
    res = (op == OP_SUBA) ? s.a + ((~iv) & dmask) + 1 : src + iv;
    n.cf = (res >> dw) & 1;
    n.zf = ((res & dmask) == 0) ? 1 : 0;
    n.pc = (s.pc + 1) & amask;
    case (op)
      OP_ADDA, OP_MOVA, OP_MOVAB, OP_INA, OP_SUBA: n.a = res & dmask;
      OP_ADDB, OP_MOVB, OP_MOVBA, OP_INB:          n.b = res & dmask;
      OP_OUTB: begin n.out_val = s.b; n.strobe = 1; end
      OP_OUTI: begin n.out_val = iv;  n.strobe = 1; end
      OP_JMP:  n.pc = imm & amask;
      OP_JNC:  if (s.cf == 0) n.pc = imm & amask;
      OP_JC:   if (s.cf != 0) n.pc = imm & amask;
      OP_JZ:   if (s.zf != 0) n.pc = imm & amask;
      OP_HALT: begin n.pc = s.pc; n.halted = 1; end
      default: ;
    endcase
    return n;
  endfunction

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s @cycle %0d: got %0d expected %0d", name, cycle, act, exp);
  endtask

  task automatic checkOutput();
    check_val("dut4.address",    int'(address4),    m4.pc);
    check_val("dut4.port_o",     int'(port_o4),     m4.out_val);
    check_val("dut4.out_strobe", int'(out_strobe4), m4.strobe);
    check_val("dut4.cf",         int'(cf4),         m4.cf);
    check_val("dut4.zf",         int'(zf4),         m4.zf);
    check_val("dut4.halted",     int'(halted4),     m4.halted);
    check_val("dut8.address",    int'(address8),    m8.pc);
    check_val("dut8.port_o",     int'(port_o8),     m8.out_val);
    check_val("dut8.out_strobe", int'(out_strobe8), m8.strobe);
    check_val("dut8.cf",         int'(cf8),         m8.cf);
    check_val("dut8.zf",         int'(zf8),         m8.zf);
    check_val("dut8.halted",     int'(halted8),     m8.halted);
  endtask

  task automatic applyStimulus(input int op, input int imm, input int pin,
                               input bit dv, input bit rs, input bit rstn);
    data4      = 8'(((op & 15) << 4) | (imm & 15));
    data8      = 12'(((op & 15) << 8) | (imm & 255));
    port_i4    = 4'(pin);
    port_i8    = 8'(pin);
    data_valid = dv;
    resume     = rs;
    rst        = rstn;
    m4 = step(m4, 4, 4, op & 15, imm & 15, pin, dv, rs, rstn);
    m8 = step(m8, 8, 6, op & 15, imm & 255, pin, dv, rs, rstn);
    @(posedge clk);
    #1;
    cycle++;
    checkOutput();
  endtask

  task automatic exec_instr(input int op, input int imm);
    applyStimulus(op, imm, 0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    applyStimulus(0, 0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    m4 = '{default: 0};
    m8 = '{default: 0};

    // Expected values for the 4-bit core, worked out by hand from reset.
    vecs[0]  = '{OP_MOVA,  9,  0,  1, 0, 0,  0, 0};
    vecs[1]  = '{OP_ADDA,  8,  0,  2, 1, 0,  0, 0};
    vecs[2]  = '{OP_JNC,   7,  0,  3, 0, 0,  0, 0};
    vecs[3]  = '{OP_JC,    7,  0,  4, 0, 0,  0, 0};
    vecs[4]  = '{OP_SUBA,  1,  0,  5, 1, 1,  0, 0};
    vecs[5]  = '{OP_JZ,    9,  0,  9, 0, 0,  0, 0};
    vecs[6]  = '{OP_MOVBA, 0,  0, 10, 0, 1,  0, 0};
    vecs[7]  = '{OP_ADDB, 15,  0, 11, 0, 0,  0, 0};
    vecs[8]  = '{OP_ADDB,  1,  0, 12, 1, 1,  0, 0};
    vecs[9]  = '{OP_OUTI, 12,  0, 13, 0, 0, 12, 1};
    vecs[10] = '{OP_INA,   0,  6, 14, 0, 0, 12, 0};
    vecs[11] = '{OP_MOVAB, 3,  0, 15, 0, 0, 12, 0};
    vecs[12] = '{OP_ADDA, 13,  0,  0, 1, 1, 12, 0};
    vecs[13] = '{OP_JMP,  14,  0, 14, 0, 0, 12, 0};
    vecs[14] = '{OP_OUTB,  0,  0, 15, 0, 1,  0, 1};
    vecs[15] = '{OP_INB,   0, 10,  0, 0, 0,  0, 0};
    vecs[16] = '{OP_OUTB,  5,  0,  1, 0, 0, 10, 1};
    vecs[17] = '{OP_SUBA,  0,  0,  2, 1, 1, 10, 0};

    do_reset();
    do_reset();
    check_val("reset.address", int'(address4), 0);
    check_val("reset.port_o",  int'(port_o4), 0);
    check_val("reset.flags",   int'({cf4, zf4, halted4, out_strobe4}), 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].imm, vecs[i].pin, 1'b1, 1'b0, 1'b1);
      check_val($sformatf("vec%0d.address", i), int'(address4),    vecs[i].pc);
      check_val($sformatf("vec%0d.cf", i),      int'(cf4),         vecs[i].cf);
      check_val($sformatf("vec%0d.zf", i),      int'(zf4),         vecs[i].zf);
      check_val($sformatf("vec%0d.port_o", i),  int'(port_o4),     vecs[i].out_val);
      check_val($sformatf("vec%0d.strobe", i),  int'(out_strobe4), vecs[i].strobe);
    end

    // Conditional jump taken on the carry left by ADD.
    do_reset();
    exec_instr(OP_MOVA, 9);
    exec_instr(OP_ADDA, 8);
    exec_instr(OP_JC, 7);
    check_val("jc_taken.address", int'(address4), 7);

    // Fetch stall: nothing may move while data_valid is low.
    exec_instr(OP_OUTI, 5);
    check_val("stall.pre_strobe", int'(out_strobe4), 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus($urandom_range(0, 15), $urandom_range(0, 255), 0, 1'b0, 1'b0, 1'b1);
      check_val("stall.address", int'(address4), 8);
      check_val("stall.strobe",  int'(out_strobe4), 0);
      check_val("stall.port_o",  int'(port_o4), 5);
    end
    exec_instr(OP_ADDA, 1);
    check_val("stall.resume_address", int'(address4), 9);

    // 8-bit I/O path.
    applyStimulus(OP_INB, 0, 'hA5, 1'b1, 1'b0, 1'b1);
    exec_instr(OP_OUTB, 0);
    check_val("io.port_o_b", int'(port_o8), 'hA5);
    check_val("io.strobe_on", int'(out_strobe8), 1);
    exec_instr(OP_ADDA, 0);
    check_val("io.strobe_off", int'(out_strobe8), 0);
    exec_instr(OP_OUTI, 'h3C);
    check_val("io.port_o_im", int'(port_o8), 'h3C);

    // HALT at address 5, hold, then resume.
    do_reset();
    for (int k = 0; k < 5; k++) exec_instr(OP_ADDA, 0);
    exec_instr(OP_HALT, 0);
    check_val("halt.halted", int'(halted4), 1);
    for (int k = 0; k < 10; k++) begin
      applyStimulus($urandom_range(0, 15), $urandom_range(0, 255), 0, 1'b1, 1'b0, 1'b1);
      check_val("halt.address_held", int'(address4), 5);
    end
    applyStimulus(OP_JMP, 0, 0, 1'b1, 1'b1, 1'b1);
    check_val("resume.address", int'(address4), 6);
    check_val("resume.halted",  int'(halted4), 0);

    // Reset while halted.
    exec_instr(OP_HALT, 0);
    do_reset();
    check_val("halt_reset.halted",  int'(halted4), 0);
    check_val("halt_reset.address", int'(address4), 0);
    exec_instr(OP_ADDA, 0);
    check_val("halt_reset.runs", int'(address4), 1);

    // PC wrap on the 6-bit address core.
    exec_instr(OP_JMP, 63);
    check_val("wrap.jmp63", int'(address8), 63);
    exec_instr(OP_ADDA, 0);
    check_val("wrap.address", int'(address8), 0);

    // Random instruction streams with stalls, resumes and occasional resets.
    for (int k = 0; k < 400; k++) begin
      applyStimulus($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 49) != 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
